// File: rtl/uart_pkg.sv
// Shared state encoding and data width for the UART transmit arbiter.
// Constants only: no latency.
// No flow control of its own.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: first asserted req after last_grant, wrapping.
// Purely combinational, zero latency.
// No flow control; any=0 when no request is present.
module rr_pick
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any
);

  logic [IDX_W-1:0] cand;

  // Walk NUM_REQ slots starting one past the previous owner; first hit wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    cand      = last_grant;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (cand == IDX_W'(NUM_REQ - 1)) ? '0 : cand + IDX_W'(1);
      if (!any && req[cand]) begin
        any        = 1'b1;
        grant[cand] = 1'b1;
        grant_idx  = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART serializer; UART_TX_ARB_TIMEOUT_EN adds a WAIT watchdog.
// Accept at cycle N -> ser_start at N+1; completion edge at M -> next accept at M+1.
// req_ready only in IDLE for the winner; all requesters are held off while a frame is in flight.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int          NUM_REQ        = 4,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd65535
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [UART_DATA_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           ser_start,
  output logic [UART_DATA_W-1:0]         ser_data,
  input  logic                           ser_done,
  output logic                           busy,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id,
  output logic                           timeout_err
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t         state;
  logic [IDX_W-1:0]   last_grant;
  logic [NUM_REQ-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic               ser_done_q;
  logic               done_edge;

`ifdef UART_TX_ARB_TIMEOUT_EN
  logic [15:0] wd_cnt;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_err    = 1'b0;
`endif

  rr_pick #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (IDX_W)
  ) u_rr_pick (
    .req       (req_valid),
    .last_grant(last_grant),
    .grant     (pick_grant),
    .grant_idx (pick_idx),
    .any       (pick_any)
  );

  assign req_ready = (state == IDLE && !rst) ? pick_grant : '0;
  assign busy      = (state != IDLE);
  // Only a fresh low-to-high transition ends a frame; a level left high from
  // the previous frame must fall first.
  assign done_edge = ser_done && !ser_done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ser_start  <= 1'b0;
      ser_data   <= '0;
      grant_id   <= '0;
      last_grant <= IDX_W'(NUM_REQ - 1);
      ser_done_q <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      timeout_err <= 1'b0;
      wd_cnt      <= '0;
`endif
    end else begin
      ser_done_q <= ser_done;
      ser_start  <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (pick_any) begin
            ser_data  <= req_data[int'(pick_idx)*UART_DATA_W +: UART_DATA_W];
            grant_id  <= pick_idx;
            ser_start <= 1'b1;
            state     <= LAUNCH;
          end
        end
        LAUNCH: begin
          state <= WAIT;
`ifdef UART_TX_ARB_TIMEOUT_EN
          wd_cnt <= '0;
`endif
        end
        WAIT: begin
          if (done_edge) begin
            last_grant <= grant_id;
            state      <= IDLE;
          end
`ifdef UART_TX_ARB_TIMEOUT_EN
          // Give up on a stuck serializer; the owner still counts as served.
          else if (wd_cnt == TIMEOUT_CYCLES - 16'd1) begin
            timeout_err <= 1'b1;
            last_grant  <= grant_id;
            state       <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 16'd1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus random traffic against a transaction-level model.
// Works with or without UART_TX_ARB_TIMEOUT_EN (DUT built with TIMEOUT_CYCLES=100).
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int TO = 100;

  logic           clk       = 1'b0;
  logic           rst       = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data  = '0;
  logic [N-1:0]   req_ready;
  logic           ser_start;
  logic [7:0]     ser_data;
  logic           ser_done  = 1'b0;
  logic           busy;
  logic [1:0]     grant_id;
  logic           timeout_err;

  int checks   = 0;
  int failures = 0;

  // serializer stand-in knobs
  int fall_lag = 0;
  int rise_dly = 5;
  bit hold_low = 1'b0;
  bit preset   = 1'b0;
  int fall_cnt = 0;
  int rise_cnt = 0;
  bit ser_active = 1'b0;

  // transaction-level model
  bit         m_inflight  = 1'b0;
  bit         m_just      = 1'b0;
  bit         m_pulse     = 1'b0;
  bit         m_prev_done = 1'b0;
  int         m_owner     = 0;
  int         m_last      = N - 1;
  int         m_age       = 0;
  logic [7:0] m_data      = '0;
  int         mon_w;
  logic [N-1:0] mon_rdy;
  bit         nxt_just;
  bit         nxt_pulse;

  uart_tx_arbiter #(
    .NUM_REQ       (N),
    .TIMEOUT_CYCLES(16'd100)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .ser_start  (ser_start),
    .ser_data   (ser_data),
    .ser_done   (ser_done),
    .busy       (busy),
    .grant_id   (grant_id),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_winner(input logic [N-1:0] v, input int last);
    for (int off = 1; off <= N; off++)
      if (v[(last + off) % N]) return (last + off) % N;
    return -1;
  endfunction

  // Serializer: sees rst/start of the cycle just ended, drops done after
  // fall_lag cycles, raises it rise_dly cycles later, holds it high after.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        ser_done   = 1'b0;
        ser_active = 1'b0;
      end else if (ser_start) begin
        fall_cnt   = fall_lag;
        rise_cnt   = rise_dly;
        ser_active = 1'b1;
        if (fall_cnt == 0) ser_done = 1'b0;
      end else if (ser_active) begin
        if (fall_cnt > 0) begin
          fall_cnt--;
          if (fall_cnt == 0) ser_done = 1'b0;
        end else if (!hold_low) begin
          rise_cnt--;
          if (rise_cnt <= 0) begin
            ser_done   = 1'b1;
            ser_active = 1'b0;
          end
        end
      end else if (preset) begin
        ser_done = 1'b1;
      end
    end
  end

  // Compare every cycle, then advance the model with this cycle's inputs.
  always @(negedge clk) begin
    mon_w   = rr_winner(req_valid, m_last);
    mon_rdy = '0;
    if (!rst && !m_inflight && mon_w >= 0) mon_rdy[mon_w] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(mon_rdy));
    chk("ser_start", 32'(ser_start), 32'(m_just));
    chk("busy", 32'(busy), 32'(m_inflight));
    chk("ser_data", 32'(ser_data), 32'(m_data));
    chk("grant_id", 32'(grant_id), m_owner);
    chk("timeout_err", 32'(timeout_err), 32'(m_pulse));

    nxt_just  = 1'b0;
    nxt_pulse = 1'b0;
    if (rst) begin
      m_inflight  = 1'b0;
      m_data      = '0;
      m_owner     = 0;
      m_last      = N - 1;
      m_age       = 0;
      m_prev_done = 1'b0;
    end else begin
      if (!m_inflight) begin
        if (mon_w >= 0) begin
          m_inflight = 1'b1;
          nxt_just   = 1'b1;
          m_owner    = mon_w;
          m_data     = req_data[mon_w*8 +: 8];
          m_age      = 0;
        end
      end else if (!m_just) begin
        if (ser_done && !m_prev_done) begin
          m_last     = m_owner;
          m_inflight = 1'b0;
        end
`ifdef UART_TX_ARB_TIMEOUT_EN
        else begin
          m_age++;
          if (m_age == TO) begin
            nxt_pulse  = 1'b1;
            m_last     = m_owner;
            m_inflight = 1'b0;
          end
        end
`endif
      end
      m_prev_done = ser_done;
    end
    m_just  = nxt_just;
    m_pulse = nxt_pulse;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    tick();
    rst       = 1'b1;
    req_valid = '1;
    repeat (2) begin
      @(negedge clk);
      chk("ready_in_reset", 32'(req_ready), 0);
      tick();
    end
    rst       = 1'b0;
    req_valid = '0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ser_start", 32'(ser_start), 0);
    chk("rst_ser_data", 32'(ser_data), 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    chk("rst_timeout_err", 32'(timeout_err), 0);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_within_budget", 32'(busy), 0);
  endtask

  int gseq[5];
  int gcyc[5];
  int exp_seq[5] = '{0, 1, 2, 3, 0};
  int got, n, done_k, pulses, pulse_k;

  initial begin
    // single request from requester 2
    do_reset();
    fall_lag = 0;
    rise_dly = 6;
    tick();
    req_valid = 4'b0100;
    req_data  = 32'h00A5_0000;
    @(negedge clk);
    chk("single_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("single_start", 32'(ser_start), 1);
    chk("single_data", 32'(ser_data), 32'hA5);
    chk("single_gid", 32'(grant_id), 2);
    wait_idle(100);

    // all four valid: strict rotation from index 0
    do_reset();
    fall_lag = 0;
    rise_dly = 20;
    tick();
    req_valid = '1;
    req_data  = 32'h4433_2211;
    got = 0;
    n   = 0;
    while (got < 5 && n < 1000) begin
      @(negedge clk);
      n++;
      if (ser_start === 1'b1) begin
        gseq[got] = int'(grant_id);
        gcyc[got] = n;
        got++;
      end
    end
    chk("rotation_frames", got, 5);
    for (int i = 0; i < 5; i++) chk("rotation_order", gseq[i], exp_seq[i]);
    chk("frame_spacing", gcyc[1] - gcyc[0], 22);
    tick();
    req_valid = '0;
    wait_idle(100);

    // done already high before launch: only the later rise completes
    do_reset();
    preset   = 1'b1;
    fall_lag = 3;
    rise_dly = 10;
    repeat (3) tick();
    req_valid = 4'b0001;
    @(negedge clk);
    chk("preset_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("preset_start", 32'(ser_start), 1);
    done_k = 0;
    for (int k = 1; k <= 100 && done_k == 0; k++) begin
      @(negedge clk);
      if (k <= 3) chk("no_early_completion", 32'(busy), 1);
      if (busy === 1'b0) done_k = k;
    end
    chk("late_edge_latency", done_k, 14);
    preset = 1'b0;

    // reset in the middle of WAIT
    do_reset();
    fall_lag = 0;
    rise_dly = 5;
    tick();
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    wait_idle(50);
    tick();
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    hold_low  = 1'b1;
    @(negedge clk);
    chk("pre_reset_gid", 32'(grant_id), 2);
    repeat (6) tick();
    rst       = 1'b1;
    req_valid = 4'b0110;
    @(negedge clk);
    chk("midframe_rst_ready", 32'(req_ready), 0);
    chk("midframe_rst_busy", 32'(busy), 1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    hold_low  = 1'b0;
    @(negedge clk);
    chk("post_rst_start", 32'(ser_start), 1);
    chk("post_rst_gid", 32'(grant_id), 1);
    wait_idle(50);

    // serializer never completes
    do_reset();
    hold_low = 1'b1;
    tick();
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("stuck_start", 32'(ser_start), 1);
    pulses  = 0;
    pulse_k = 0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (timeout_err === 1'b1) begin
        pulses++;
        pulse_k = k;
      end
    end
`ifdef UART_TX_ARB_TIMEOUT_EN
    chk("timeout_pulses", pulses, 1);
    chk("timeout_cycle", pulse_k, 101);
    chk("timeout_idle", 32'(busy), 0);
`else
    chk("no_timeout_pulses", pulses, 0);
    chk("stuck_busy", 32'(busy), 1);
`endif
    hold_low = 1'b0;

    // random traffic with occasional reset
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      tick();
      req_valid = N'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) req_valid = '0;
      req_data = $urandom;
      fall_lag = $urandom_range(0, 2);
      rise_dly = $urandom_range(1, 8);
      rst      = ($urandom_range(0, 199) == 0);
    end
    tick();
    rst       = 1'b0;
    req_valid = '0;
    repeat (20) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
